lcg_stim_gen: RTL and testbench

Synthesizable, parametrised stimulus generator that replaces behavioural testbench drivers. It produces wide input vectors for a device under test using the team's 32-bit LCG sequence, with the same word packing as the existing simulation drivers. It adds selectable pattern modes, a cycle budget, and a valid/ready output handshake. It sits between a test controller (seed, mode, count) and the DUT's flat input bus, and is usable in simulation and on FPGA.

---
 rtl/lcg_stim_pkg.sv | 34 +++
 rtl/lcg_stim_gen_if.sv | 23 ++
 rtl/lcg_stim_gen_lcg32_core.sv | 41 ++++
 rtl/lcg_stim_gen.sv | 180 ++++++++++++++++++
 tb/tb_lcg_stim_gen.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcg_stim_pkg.sv
// Shared types, default LCG constants and the LCG step function for the
// stimulus generator family.
package lcg_stim_pkg;

    typedef enum logic [1:0] {
        MODE_LCG   = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_WALK1 = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [31:0] DEF_LCG_A = 32'h41C64E6D;
    localparam logic [31:0] DEF_LCG_C = 32'h3039;

    // One LCG step with explicit constants, arithmetic mod 2^32.
    function automatic logic [31:0] lcg_step(input logic [31:0] state,
                                             input logic [31:0] mul,
                                             input logic [31:0] inc);
        return state * mul + inc;
    endfunction

    // One LCG step with the default team constants.
    function automatic logic [31:0] lcg_next(input logic [31:0] state);
        return lcg_step(state, DEF_LCG_A, DEF_LCG_C);
    endfunction

endpackage

// File: rtl/lcg_stim_gen_if.sv
// Valid/ready vector bus from the stimulus generator to its consumer.
interface lcg_stim_gen_if #(
    parameter int OUT_W = 258
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [31:0]      out_index;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/lcg_stim_gen_lcg32_core.sv
// 32-bit LCG state register with load and step controls; load wins over step.
module lcg32_core
    import lcg_stim_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'd1948728483,
    parameter logic [31:0] LCG_A = DEF_LCG_A,
    parameter logic [31:0] LCG_C = DEF_LCG_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] seed_i,
    output logic [31:0] state_o,
    output logic [31:0] next_state_o
);
    logic [31:0] state_q;
    logic [31:0] state_d;

    assign next_state_o = lcg_step(state_q, LCG_A, LCG_C);
    assign state_o      = state_q;

    // Select the next LCG state: reload, advance or hold.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (step_i) begin
            state_d = next_state_o;
        end
    end

    // LCG state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end
endmodule

// File: rtl/lcg_stim_gen.sv
// LCG-based stimulus generator: fills an OUT_W-bit vector one 32-bit word per
// cycle, then presents it on a valid/ready bus; cfg_count+1 vectors per run.
module lcg_stim_gen
    import lcg_stim_pkg::*;
#(
    parameter int          OUT_W    = 258,
    parameter logic [31:0] DEF_SEED = 32'd1948728483,
    parameter logic [31:0] LCG_A    = DEF_LCG_A,
    parameter logic [31:0] LCG_C    = DEF_LCG_C
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [31:0]    cfg_seed,
    input  logic [1:0]     cfg_mode,
    input  logic [31:0]    cfg_count,
    output logic           busy,
    output logic           done,
    output logic [31:0]    rng_state_o,
    lcg_stim_gen_if.master out_if
);
    localparam int NWORDS = (OUT_W + 31) / 32;
    localparam int WCNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int WALK_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        index_q, index_d;
    logic [WALK_W-1:0]  walk_q, walk_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [OUT_W-1:0]   shadow_q, shadow_d;
    logic [OUT_W-1:0]   data_q, data_d;

    logic [31:0]        next_state;
    logic               rng_load;
    logic               rng_step;
    logic               last_word;
    logic               last_vec;
    logic               handshake;
    logic               valid;
    logic [OUT_W-1:0]   shadow_wr;
    logic [OUT_W-1:0]   walk_vec;
    logic [OUT_W-1:0]   fill_vec;

    assign rng_load  = (state_q == ST_IDLE) && start;
    assign rng_step  = (state_q == ST_FILL);
    assign last_word = (wcnt_q == WCNT_W'(NWORDS - 1));
    assign last_vec  = (index_q == count_q);
    assign handshake = valid && out_if.out_ready;

    lcg32_core #(
        .SEED  (DEF_SEED),
        .LCG_A (LCG_A),
        .LCG_C (LCG_C)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .load_i       (rng_load),
        .step_i       (rng_step),
        .seed_i       (cfg_seed),
        .state_o      (rng_state_o),
        .next_state_o (next_state)
    );

    // Shadow register with the word selected by the word counter replaced by
    // the freshly stepped LCG state; bits past OUT_W in the last word drop out.
    always_comb begin
        shadow_wr = shadow_q;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            if (wcnt_q == WCNT_W'(i / 32)) begin
                shadow_wr[i] = next_state[5'(i % 32)];
            end
        end
    end

    // Walking-one position is tracked incrementally instead of index mod OUT_W.
    always_comb begin
        walk_vec         = '0;
        walk_vec[walk_q] = 1'b1;
        case (mode_q)
            MODE_COUNT: fill_vec = OUT_W'(index_q);
            MODE_WALK1: fill_vec = walk_vec;
            default:    fill_vec = shadow_wr;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_FILL;
            ST_FILL:    if (last_word) state_d = ST_PRESENT;
            ST_PRESENT: if (handshake) state_d = last_vec ? ST_DONE : ST_FILL;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        busy  = (state_q != ST_IDLE);
        done  = (state_q == ST_DONE);
        valid = (state_q == ST_PRESENT);
    end

    assign out_if.out_valid = valid;
    assign out_if.out_data  = data_q;
    assign out_if.out_index = index_q;

    // Datapath next-state: config capture, word fill, index/walk advance.
    always_comb begin
        mode_d   = mode_q;
        count_d  = count_q;
        index_d  = index_q;
        walk_d   = walk_q;
        wcnt_d   = wcnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode_e'(cfg_mode);
                    count_d = cfg_count;
                    index_d = '0;
                    walk_d  = '0;
                    wcnt_d  = '0;
                end
            end
            ST_FILL: begin
                wcnt_d = wcnt_q + WCNT_W'(1);
                if (mode_q == MODE_LCG || mode_q == MODE_RSVD) begin
                    shadow_d = shadow_wr;
                end
                if (last_word) begin
                    data_d = fill_vec;
                    wcnt_d = '0;
                end
            end
            ST_PRESENT: begin
                if (handshake && !last_vec) begin
                    index_d = index_q + 32'd1;
                    walk_d  = (walk_q == WALK_W'(OUT_W - 1)) ? '0 : walk_q + WALK_W'(1);
                    wcnt_d  = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_LCG;
            count_q  <= '0;
            index_q  <= '0;
            walk_q   <= '0;
            wcnt_q   <= '0;
            shadow_q <= '0;
            data_q   <= '0;
        end else begin
            mode_q   <= mode_d;
            count_q  <= count_d;
            index_q  <= index_d;
            walk_q   <= walk_d;
            wcnt_q   <= wcnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
        end
    end
endmodule

// File: tb/tb_lcg_stim_gen.sv
// Self-checking bench for lcg_stim_gen: 258-bit instance against a software
// LCG model, plus 64-bit and 8-bit instances for fixed-value corner cases.
module tb_lcg_stim_gen;
    import lcg_stim_pkg::*;

    localparam int          W     = 258;
    localparam int          NW    = 9;
    localparam logic [31:0] DSEED = 32'd1948728483;

    typedef struct {
        logic [31:0] seed;
        logic [1:0]  mode;
        logic [31:0] count;
        int unsigned low_pct;
    } run_t;

    typedef struct {
        logic [31:0] idx;
        logic [7:0]  data;
    } vec8_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 258-bit instance
    logic        start, busy, done;
    logic [31:0] cfg_seed, cfg_count, rng;
    logic [1:0]  cfg_mode;
    lcg_stim_gen_if #(.OUT_W(W)) bus ();
    lcg_stim_gen #(.OUT_W(W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .cfg_seed(cfg_seed), .cfg_mode(cfg_mode),
        .cfg_count(cfg_count), .busy(busy), .done(done), .rng_state_o(rng), .out_if(bus)
    );

    // 64-bit instance
    logic        start64, busy64, done64;
    logic [31:0] seed64, count64, rng64;
    logic [1:0]  mode64;
    lcg_stim_gen_if #(.OUT_W(64)) bus64 ();
    lcg_stim_gen #(.OUT_W(64)) u_dut64 (
        .clk(clk), .rst(rst), .start(start64), .cfg_seed(seed64), .cfg_mode(mode64),
        .cfg_count(count64), .busy(busy64), .done(done64), .rng_state_o(rng64), .out_if(bus64)
    );

    // 8-bit instance
    logic        start8, busy8, done8;
    logic [31:0] seed8, count8, rng8;
    logic [1:0]  mode8;
    lcg_stim_gen_if #(.OUT_W(8)) bus8 ();
    lcg_stim_gen #(.OUT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .cfg_seed(seed8), .cfg_mode(mode8),
        .cfg_count(count8), .busy(busy8), .done(done8), .rng_state_o(rng8), .out_if(bus8)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] m_rng;
    run_t        runs [6];
    vec8_t       walk_tab [10];
    vec8_t       cnt_tab [4];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sw_lcg(input logic [31:0] s);
        return s * 32'h41C64E6D + 32'h3039;
    endfunction

    // Expected vector: the model LCG always takes NW steps per vector.
    function automatic logic [W-1:0] model_vec(input logic [1:0] mode, input logic [31:0] idx);
        logic [NW*32-1:0] acc;
        logic [W-1:0]     one;
        acc = '0;
        one = 1;
        for (int k = 0; k < NW; k++) begin
            m_rng = sw_lcg(m_rng);
            acc[k*32 +: 32] = m_rng;
        end
        case (mode)
            2'd1:    return W'(idx);
            2'd2:    return one << (idx % W);
            default: return acc[W-1:0];
        endcase
    endfunction

    // One run on the 258-bit instance with random backpressure, stray start
    // pulses and scrambled cfg after acceptance.
    task automatic run258(input logic [31:0] seed, input logic [1:0] mode,
                          input logic [31:0] count, input int unsigned low_pct);
        logic [W-1:0] exp_vec;
        logic [31:0]  exp_idx;
        int unsigned  since;
        logic         waiting, finished, hold;
        @(negedge clk);
        start = 1'b1; cfg_seed = seed; cfg_mode = mode; cfg_count = count;
        bus.out_ready = 1'b0;
        m_rng   = seed;
        exp_idx = 0;
        exp_vec = model_vec(mode, 0);
        since = 0; waiting = 1'b1; finished = 1'b0; hold = 1'b0;
        for (int unsigned cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(negedge clk);
            since++;
            start     = ($urandom_range(99) < 15);
            cfg_seed  = $urandom;
            cfg_mode  = 2'($urandom_range(3));
            cfg_count = $urandom_range(3);
            if (bus.out_valid) begin
                if (waiting) begin
                    // NW cycles of valid low after the start/handshake cycle
                    check("latency", W'(since), W'(NW + 1));
                    check("busy_run", W'(busy), W'(1));
                    waiting = 1'b0;
                end
                check("out_index", W'(bus.out_index), W'(exp_idx));
                check("out_data", bus.out_data, exp_vec);
                bus.out_ready = ($urandom_range(99) >= low_pct);
                if (bus.out_ready) begin
                    hold = 1'b0;
                    if (exp_idx == count) begin
                        finished = 1'b1;
                    end else begin
                        exp_idx++;
                        exp_vec = model_vec(mode, exp_idx);
                        since   = 0;
                        waiting = 1'b1;
                    end
                end else begin
                    hold = 1'b1;
                end
            end else begin
                bus.out_ready = 1'($urandom_range(1));
                if (hold) begin
                    check("valid_dropped", W'(0), W'(1));
                    hold = 1'b0;
                end
            end
        end
        if (!finished) check("run_timeout", W'(0), W'(1));
        @(negedge clk);
        start = 1'b1; cfg_seed = $urandom; cfg_count = $urandom_range(5);
        check("done_pulse", W'(done), W'(1));
        check("valid_after_last", W'(bus.out_valid), W'(0));
        check("rng_state", W'(rng), W'(m_rng));
        @(negedge clk);
        start = 1'b0;
        check("done_clear", W'(done), W'(0));
        check("busy_idle", W'(busy), W'(0));
        @(negedge clk);
        check("start_in_done_ignored", W'(busy), W'(0));
    endtask

    // One run on the 8-bit instance compared with a constant table.
    task automatic run8(input logic [1:0] mode, input int unsigned nvec);
        int unsigned n;
        logic [7:0]  exp_d;
        logic [31:0] exp_i;
        @(negedge clk);
        start8 = 1'b1; seed8 = $urandom; mode8 = mode; count8 = nvec - 1;
        bus8.out_ready = 1'b0;
        n = 0;
        for (int unsigned cyc = 0; cyc < 500 && n < nvec; cyc++) begin
            @(negedge clk);
            start8 = 1'b0;
            bus8.out_ready = ($urandom_range(99) >= 30);
            if (bus8.out_valid) begin
                exp_d = (mode == 2'd2) ? walk_tab[n].data : cnt_tab[n].data;
                exp_i = (mode == 2'd2) ? walk_tab[n].idx : cnt_tab[n].idx;
                check("w8_index", W'(bus8.out_index), W'(exp_i));
                check("w8_data", W'(bus8.out_data), W'(exp_d));
                if (bus8.out_ready) n++;
            end
        end
        if (n < nvec) check("w8_timeout", W'(n), W'(nvec));
        @(negedge clk);
        bus8.out_ready = 1'b0;
        check("w8_done", W'(done8), W'(1));
        @(negedge clk);
    endtask

    initial begin
        int unsigned since;
        logic        got;
        start = 1'b0; cfg_seed = '0; cfg_mode = '0; cfg_count = '0; bus.out_ready = 1'b0;
        start64 = 1'b0; seed64 = '0; mode64 = '0; count64 = '0; bus64.out_ready = 1'b0;
        start8 = 1'b0; seed8 = '0; mode8 = '0; count8 = '0; bus8.out_ready = 1'b0;

        runs[0] = '{DSEED,    2'd0, 32'd100, 0};
        runs[1] = '{$urandom, 2'd0, 32'd20,  30};
        runs[2] = '{$urandom, 2'd1, 32'd3,   0};
        runs[3] = '{$urandom, 2'd2, 32'd5,   30};
        runs[4] = '{$urandom, 2'd3, 32'd2,   30};
        runs[5] = '{$urandom, 2'd1, 32'd7,   30};
        walk_tab = '{'{32'd0, 8'h01}, '{32'd1, 8'h02}, '{32'd2, 8'h04}, '{32'd3, 8'h08},
                     '{32'd4, 8'h10}, '{32'd5, 8'h20}, '{32'd6, 8'h40}, '{32'd7, 8'h80},
                     '{32'd8, 8'h01}, '{32'd9, 8'h02}};
        cnt_tab  = '{'{32'd0, 8'h00}, '{32'd1, 8'h01}, '{32'd2, 8'h02}, '{32'd3, 8'h03}};

        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_valid", W'(bus.out_valid), W'(0));
        check("rst_index", W'(bus.out_index), W'(0));
        check("rst_data", bus.out_data, W'(0));
        check("rst_rng", W'(rng), W'(DSEED));
        check("rst_rng64", W'(rng64), W'(DSEED));
        check("rst_valid8", W'(bus8.out_valid), W'(0));
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run258(runs[i].seed, runs[i].mode, runs[i].count, runs[i].low_pct);
        end

        // 64-bit, seed 0: one known vector, first valid 3 edges after start
        @(negedge clk);
        start64 = 1'b1; seed64 = '0; mode64 = 2'd0; count64 = '0; bus64.out_ready = 1'b1;
        since = 0; got = 1'b0;
        for (int unsigned cyc = 0; cyc < 30 && !got; cyc++) begin
            @(negedge clk);
            start64 = 1'b0;
            since++;
            if (bus64.out_valid) begin
                got = 1'b1;
                check("w64_latency", W'(since), W'(3));
                check("w64_data", W'(bus64.out_data), W'(64'hD3DC167E_00003039));
                check("w64_index", W'(bus64.out_index), W'(0));
            end
        end
        if (!got) check("w64_timeout", W'(0), W'(1));
        @(negedge clk);
        check("w64_done", W'(done64), W'(1));
        check("w64_valid_low", W'(bus64.out_valid), W'(0));
        @(negedge clk);
        check("w64_done_clear", W'(done64), W'(0));
        check("w64_busy_idle", W'(busy64), W'(0));

        run8(2'd2, 10);
        run8(2'd1, 4);

        // reset during FILL of vector 5, then a fresh run reproduces vector 0
        @(negedge clk);
        start = 1'b1; cfg_seed = DSEED; cfg_mode = 2'd0; cfg_count = 32'd10; bus.out_ready = 1'b1;
        got = 1'b0;
        for (int unsigned cyc = 0; cyc < 300 && !got; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.out_index == 32'd5 && !bus.out_valid && busy) got = 1'b1;
        end
        if (!got) check("fill5_timeout", W'(0), W'(1));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_valid", W'(bus.out_valid), W'(0));
        check("midrst_index", W'(bus.out_index), W'(0));
        check("midrst_rng", W'(rng), W'(DSEED));
        check("midrst_data", bus.out_data, W'(0));
        rst = 1'b0;
        run258(DSEED, 2'd0, 32'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
